// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter.
// No logic of its own; imported by period_meter.
// Holds the FSM state encoding and the synchronizer depth floor.
package period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    // Fewer than two flops gives no metastability margin on sig_in.
    localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level and produces one-cycle rise/fall pulses.
// Latency: STAGES cycles to level, STAGES+1 cycles to the registered rise/fall.
// No backpressure: free-running every clk cycle.
//
// Ports:
//   clk, reset  - clock and asynchronous active-high reset (all flops clear to 0)
//   sig_in      - asynchronous input
//   level       - synchronized copy of sig_in
//   rise, fall  - single-cycle pulses on a synchronized 0->1 / 1->0 transition
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] syncChain;
    logic              levelDly;

    assign level = syncChain[STAGES-1];

    // Edge pulses are registered so downstream logic sees flop outputs only;
    // the extra cycle is constant and cancels out of any interval measurement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncChain <= '0;
            levelDly  <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            syncChain <= {syncChain[STAGES-2:0], sig_in};
            levelDly  <= syncChain[STAGES-1];
            rise      <= syncChain[STAGES-1] & ~levelDly;
            fall      <= ~syncChain[STAGES-1] & levelDly;
        end
    end

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles.
// Latency: valid SYNC_STAGES+2 cycles after the second rising edge of sig_in.
// No backpressure: start is ignored (not queued) while busy; results held until next valid.
//
// Ports:
//   clk, reset          - clock and asynchronous active-high reset
//   sig_in              - asynchronous signal under measurement
//   start               - one-cycle request to arm a single measurement
//   period, high_time   - last completed measurement (WIDTH-bit, unsigned)
//   valid               - one-cycle pulse when period/high_time update
//   busy                - a measurement is armed or in progress
//   timeout             - sticky counter-saturation flag, cleared by an accepted start
module period_meter
    import period_meter_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             start,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             busy,
    output logic             timeout
);

    localparam int STAGES_USED = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    // Saturation is declared on the cycle the count would reach all-ones, so the
    // largest reportable period is all-ones minus one.
    localparam logic [WIDTH-1:0] CNT_LAST = CNT_MAX - CNT_ONE;

    logic sigRise;
    logic sigFall;
    logic unusedLevel;  // level output only serves other users of the synchronizer

    sync_edge_detect #(
        .STAGES (STAGES_USED)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .sig_in (sig_in),
        .level  (unusedLevel),
        .rise   (sigRise),
        .fall   (sigFall)
    );

    state_t           state, stateNext;
    logic [WIDTH-1:0] cnt, cntNext;
    logic [WIDTH-1:0] hiCnt, hiCntNext;
    logic             hiSeen, hiSeenNext;
    logic [WIDTH-1:0] periodNext, highTimeNext;
    logic             validNext, timeoutNext;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            hiCnt     <= '0;
            hiSeen    <= 1'b0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            hiCnt     <= hiCntNext;
            hiSeen    <= hiSeenNext;
            period    <= periodNext;
            high_time <= highTimeNext;
            valid     <= validNext;
            timeout   <= timeoutNext;
        end
    end

    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        hiCntNext    = hiCnt;
        hiSeenNext   = hiSeen;
        periodNext   = period;
        highTimeNext = high_time;
        validNext    = 1'b0;
        timeoutNext  = timeout;

        unique case (state)
            IDLE: begin
                // A rise coinciding with start is deliberately dropped: the
                // measurement begins at the next rise seen from ARM.
                if (start) begin
                    stateNext   = ARM;
                    cntNext     = '0;
                    timeoutNext = 1'b0;
                    hiSeenNext  = 1'b0;
                end
            end

            ARM: begin
                if (sigRise) begin
                    stateNext = MEASURE;
                    cntNext   = CNT_ONE;
                end else if (cnt == CNT_LAST) begin
                    stateNext   = IDLE;
                    cntNext     = CNT_MAX;
                    timeoutNext = 1'b1;
                end else begin
                    cntNext = cnt + CNT_ONE;
                end
            end

            MEASURE: begin
                if (sigRise) begin
                    // High time is staged in hiCnt and published together with
                    // period, so a timed-out run leaves both outputs untouched.
                    periodNext   = cnt;
                    highTimeNext = hiCnt;
                    validNext    = 1'b1;
                    stateNext    = IDLE;
                end else begin
                    if (sigFall && !hiSeen) begin
                        hiCntNext  = cnt;
                        hiSeenNext = 1'b1;
                    end
                    if (cnt == CNT_LAST) begin
                        stateNext   = IDLE;
                        cntNext     = CNT_MAX;
                        timeoutNext = 1'b1;
                    end else begin
                        cntNext = cnt + CNT_ONE;
                    end
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_period_meter.sv
module tb_period_meter;

    localparam int W  = 8;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         sig_in;
    logic         start;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         busy;
    logic         timeout;

    always #5 clk = ~clk;

    period_meter #(
        .WIDTH       (W),
        .SYNC_STAGES (SS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sig_in    (sig_in),
        .start     (start),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .busy      (busy),
        .timeout   (timeout)
    );

    int checks = 0;
    int errors = 0;

    task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Square-wave source: high genHi cycles, low genLo cycles, first rise genOfs
    // time units after the call (negedges are at multiples of 10, posedges at 5 mod 10).
    int genHi = 1, genLo = 1, genOfs = 2;
    bit genRun = 1'b0, genActive = 1'b0;

    initial begin
        sig_in = 1'b0;
        forever begin
            wait (genRun);
            genActive = 1'b1;
            #(genOfs);
            while (genRun) begin
                sig_in = 1'b1;
                #(genHi * 10);
                sig_in = 1'b0;
                #(genLo * 10);
            end
            genActive = 1'b0;
        end
    end

    task automatic startGen(input int hi, input int lo, input int ofs);
        genHi  = hi;
        genLo  = lo;
        genOfs = ofs;
        genRun = 1'b1;
    endtask

    task automatic stopGen();
        genRun = 1'b0;
        wait (!genActive);
        @(negedge clk);
    endtask

    // Scoreboard
    typedef struct {
        int p;
        int h;
    } exp_t;

    exp_t expQ[$];
    exp_t expCur;
    int   lastP = 0;
    int   lastH = 0;

    always @(negedge clk) begin
        if (valid) begin
            if (expQ.size() == 0) begin
                checkEq("unexpected_valid", valid, 0);
            end else begin
                expCur = expQ.pop_front();
                checkEq("period", period, expCur.p);
                checkEq("high_time", high_time, expCur.h);
                checkEq("busy_at_valid", busy, 0);
                lastP = expCur.p;
                lastH = expCur.h;
            end
        end
    end

    task automatic pushExp(input int p, input int h);
        exp_t e;
        e.p = p;
        e.h = h;
        expQ.push_back(e);
    endtask

    // Called at a negedge; leaves start high for exactly one posedge.
    task automatic pulseStart(input bit doPush, input int p, input int h);
        start = 1'b1;
        if (doPush) pushExp(p, h);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int k = 0;
        while (expQ.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkEq("scoreboard_drained", expQ.size(), 0);
    endtask

    initial begin
        int ofsTab[4];
        int k;
        ofsTab[0] = 1; ofsTab[1] = 4; ofsTab[2] = 6; ofsTab[3] = 9;

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkEq("rst_period", period, 0);
        checkEq("rst_high_time", high_time, 0);
        checkEq("rst_valid", valid, 0);
        checkEq("rst_busy", busy, 0);
        checkEq("rst_timeout", timeout, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Divide-by-2 input
        startGen(1, 1, 2);
        repeat (4) @(negedge clk);
        pulseStart(1'b1, 2, 1);
        checkEq("busy_after_start", busy, 1);
        waitDrain(50);
        stopGen();

        // 25 % duty cycle, start in the middle of the low phase
        startGen(25, 75, 3);
        repeat (60) @(negedge clk);
        pulseStart(1'b1, 100, 25);
        waitDrain(300);
        checkEq("timeout_25pct", timeout, 0);

        // start during MEASURE is ignored; start on the valid cycle is accepted
        repeat (30) @(negedge clk);
        pulseStart(1'b1, 100, 25);
        @(posedge sig_in);
        repeat (10) @(negedge clk);
        checkEq("busy_in_measure", busy, 1);
        pulseStart(1'b0, 0, 0);
        k = 0;
        while (!valid && k < 300) begin
            @(negedge clk);
            k++;
        end
        checkEq("valid_seen", valid, 1);
        start = 1'b1;
        pushExp(100, 25);
        @(negedge clk);
        start = 1'b0;
        checkEq("busy_after_restart", busy, 1);
        waitDrain(300);
        stopGen();

        // Timeout: sig_in held low, 255 cycles in ARM
        checkEq("sig_low_before_timeout", sig_in, 0);
        pulseStart(1'b0, 0, 0);
        checkEq("busy_timeout_run", busy, 1);
        repeat (254) @(negedge clk);
        checkEq("busy_before_saturate", busy, 1);
        checkEq("timeout_before_saturate", timeout, 0);
        @(negedge clk);
        checkEq("busy_after_saturate", busy, 0);
        checkEq("timeout_set", timeout, 1);
        checkEq("period_kept", period, lastP);
        checkEq("high_time_kept", high_time, lastH);
        repeat (5) @(negedge clk);
        checkEq("timeout_sticky", timeout, 1);

        // Next accepted start clears timeout; measure 30/70 wave
        pulseStart(1'b0, 0, 0);
        checkEq("timeout_cleared", timeout, 0);
        startGen(30, 70, 7);
        pushExp(100, 30);
        waitDrain(300);

        // Reset in the middle of MEASURE
        repeat (20) @(negedge clk);
        pulseStart(1'b0, 0, 0);
        @(posedge sig_in);
        repeat (20) @(negedge clk);
        checkEq("busy_before_reset", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        checkEq("mid_rst_period", period, 0);
        checkEq("mid_rst_high_time", high_time, 0);
        checkEq("mid_rst_valid", valid, 0);
        checkEq("mid_rst_busy", busy, 0);
        checkEq("mid_rst_timeout", timeout, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (150) @(negedge clk);
        checkEq("idle_after_reset", busy, 0);
        pulseStart(1'b1, 100, 30);
        waitDrain(300);
        stopGen();

        // Asynchronous edge placement, period 50
        for (int i = 0; i < 4; i++) begin
            startGen(20, 30, ofsTab[i]);
            repeat (10) @(negedge clk);
            pulseStart(1'b1, 50, 20);
            waitDrain(200);
            stopGen();
        end

        repeat (10) @(negedge clk);
        checkEq("final_queue_empty", expQ.size(), 0);
        checkEq("final_busy", busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
